// File: rtl/countdown_timer.sv
// countdown_timer: loadable multi-digit BCD down-counter.
// A prescaler divides clk_i down to one decrement every TICK_DIV cycles while
// running. Digits borrow LSD-first, and the decrement that reaches all-zero
// parks the timer in DONE with a one-cycle zero strobe. All outputs are
// registered, and running_o is decoded from the state register only.
module countdown_timer #(
  parameter int TICK_DIV = 500000,
  parameter int DIGITS   = 4
) (
  input  logic                  clk_i,
  input  logic                  res_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   load_val_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  output logic [4*DIGITS-1:0]   digits_o,
  output logic                  running_o,
  output logic                  zero_stb_o,
  output logic                  tick_o
);

  localparam int DW = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Saturate every nibble of a raw load word to a legal BCD digit (0..9).
  function automatic logic [DW-1:0] bcd_clamp(input logic [DW-1:0] v);
    logic [DW-1:0] res;
    logic [3:0]    d;
    res = '0;
    for (int k = 0; k < DIGITS; k++) begin
      d = v[4*k +: 4];
      res[4*k +: 4] = (d > 4'd9) ? 4'd9 : d;
    end
    return res;
  endfunction

  // BCD minus one with digit-to-digit borrow; all-zero saturates at zero so
  // the counter can never wrap to 99..9.
  function automatic logic [DW-1:0] bcd_dec(input logic [DW-1:0] v);
    logic [DW-1:0] res;
    logic [3:0]    d;
    logic          borrow;
    res    = v;
    borrow = 1'b1;
    if (v != '0) begin
      for (int k = 0; k < DIGITS; k++) begin
        d = v[4*k +: 4];
        if (borrow) begin
          if (d == 4'd0) begin
            d = 4'd9;
          end else begin
            d      = d - 4'd1;
            borrow = 1'b0;
          end
        end
        res[4*k +: 4] = d;
      end
    end
    return res;
  endfunction

  state_t        r_state;
  logic [DW-1:0] r_digits;
  logic [PW-1:0] r_presc;
  logic          r_zero_stb;
  logic          r_tick;

  state_t        w_state_nx;
  logic [DW-1:0] w_digits_nx;
  logic [PW-1:0] w_presc_nx;
  logic          w_zero_stb_nx;
  logic          w_tick_nx;

  logic [DW-1:0] w_digits_dec;
  logic          w_dec_is_zero;
  logic          w_digits_nz;
  logic          w_presc_wrap;

  assign w_digits_dec  = bcd_dec(r_digits);
  assign w_dec_is_zero = (w_digits_dec == '0);
  assign w_digits_nz   = (r_digits != '0);
  assign w_presc_wrap  = (r_presc == PRESC_MAX);

  // State, value, prescaler and strobe registers; reset overrides everything.
  always_ff @(posedge clk_i) begin
    if (res_i) begin
      r_state    <= IDLE;
      r_digits   <= '0;
      r_presc    <= '0;
      r_zero_stb <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_digits   <= w_digits_nx;
      r_presc    <= w_presc_nx;
      r_zero_stb <= w_zero_stb_nx;
      r_tick     <= w_tick_nx;
    end
  end

  // Next-state logic: load beats stop, stop beats start, in every state.
  always_comb begin
    w_state_nx    = r_state;
    w_digits_nx   = r_digits;
    w_presc_nx    = r_presc;
    w_zero_stb_nx = 1'b0;
    w_tick_nx     = 1'b0;

    if (load_i) begin
      // Load also cancels a terminal tick landing in the same cycle.
      w_digits_nx = bcd_clamp(load_val_i);
      w_presc_nx  = '0;
      w_state_nx  = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          // Starting from zero is meaningless, so it is silently dropped.
          if (!stop_i && start_i && w_digits_nz) begin
            w_state_nx = RUN;
            w_presc_nx = '0;
          end
        end
        RUN: begin
          if (stop_i) begin
            // Prescaler is frozen so the partial tick survives the pause.
            w_state_nx = PAUSED;
          end else if (w_presc_wrap) begin
            w_presc_nx  = '0;
            w_digits_nx = w_digits_dec;
            w_tick_nx   = 1'b1;
            if (w_dec_is_zero) begin
              w_state_nx    = DONE;
              w_zero_stb_nx = 1'b1;
            end
          end else begin
            w_presc_nx = r_presc + PW'(1);
          end
        end
        PAUSED: begin
          if (!stop_i && start_i) begin
            w_state_nx = RUN;
          end
        end
        DONE: begin
          w_digits_nx = '0;
        end
        default: begin
          w_state_nx = IDLE;
        end
      endcase
    end
  end

  assign digits_o   = r_digits;
  assign running_o  = (r_state == RUN);
  assign zero_stb_o = r_zero_stb;
  assign tick_o     = r_tick;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICK_DIV=4, DIGITS=4.
// Expected output tuples are queued as each step is driven and are compared
// against the DUT one time unit after the following rising edge.
module tb_countdown_timer;

  localparam int TD = 4;
  localparam int DG = 4;

  logic          clk = 1'b0;
  logic          res = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   load_val = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [15:0]   digits;
  logic          running;
  logic          zero_stb;
  logic          tick;

  int checks   = 0;
  int failures = 0;

  string       tag_q[$];
  logic [18:0] exp_q[$];

  countdown_timer #(.TICK_DIV(TD), .DIGITS(DG)) dut (
    .clk_i      (clk),
    .res_i      (res),
    .load_i     (load),
    .load_val_i (load_val),
    .start_i    (start),
    .stop_i     (stop),
    .digits_o   (digits),
    .running_o  (running),
    .zero_stb_o (zero_stb),
    .tick_o     (tick)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic expect_o(input string tag, input logic [15:0] d,
                          input logic r, input logic z, input logic t);
    tag_q.push_back(tag);
    exp_q.push_back({d, r, z, t});
  endtask

  task automatic chk(input string tag, input string fld,
                     input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s.%s got=%h exp=%h", tag, fld, got, exp);
    end
  endtask

  // Advance one clock and compare every expectation queued for this edge.
  task automatic cyc();
    string       t;
    logic [18:0] e;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      chk(t, "digits",   digits,          e[18:3]);
      chk(t, "running",  {15'd0, running},  {15'd0, e[2]});
      chk(t, "zero_stb", {15'd0, zero_stb}, {15'd0, e[1]});
      chk(t, "tick",     {15'd0, tick},     {15'd0, e[0]});
    end
  endtask

  // Expect value held for n cycles while running with no tick.
  task automatic run_hold(input string tag, input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      expect_o(tag, d, 1'b1, 1'b0, 1'b0);
      cyc();
    end
  endtask

  logic [15:0] chain [4];

  initial begin
    chain[0] = 16'h0101;
    chain[1] = 16'h0100;
    chain[2] = 16'h0099;
    chain[3] = 16'h0098;

    // Reset values
    res = 1'b1;
    expect_o("reset1", 16'h0000, 1'b0, 1'b0, 1'b0); cyc();
    expect_o("reset2", 16'h0000, 1'b0, 1'b0, 1'b0); cyc();
    res = 1'b0;

    // Clamp of out-of-range digit on load
    load = 1'b1; load_val = 16'h00F9;
    expect_o("clamp", 16'h0099, 1'b0, 1'b0, 1'b0); cyc();
    load = 1'b0;

    // Start and stop together from IDLE stays IDLE
    start = 1'b1; stop = 1'b1;
    expect_o("startstop", 16'h0099, 1'b0, 1'b0, 1'b0); cyc();
    start = 1'b0; stop = 1'b0;
    expect_o("startstop_hold", 16'h0099, 1'b0, 1'b0, 1'b0); cyc();

    // Start with zero value is ignored
    load = 1'b1; load_val = 16'h0000;
    expect_o("load0", 16'h0000, 1'b0, 1'b0, 1'b0); cyc();
    load = 1'b0; start = 1'b1;
    expect_o("start0", 16'h0000, 1'b0, 1'b0, 1'b0); cyc();
    start = 1'b0;
    expect_o("start0_hold", 16'h0000, 1'b0, 1'b0, 1'b0); cyc();

    // Borrow chain 0102 -> 0098
    load = 1'b1; load_val = 16'h0102;
    expect_o("load0102", 16'h0102, 1'b0, 1'b0, 1'b0); cyc();
    load = 1'b0; start = 1'b1;
    expect_o("chain_start", 16'h0102, 1'b1, 1'b0, 1'b0); cyc();
    start = 1'b0;
    for (int s = 0; s < 4; s++) begin
      run_hold("chain_wait", (s == 0) ? 16'h0102 : chain[s-1], 3);
      expect_o("chain_step", chain[s], 1'b1, 1'b0, 1'b1); cyc();
    end

    // Reset mid-run
    run_hold("prereset", 16'h0098, 2);
    res = 1'b1;
    expect_o("reset_mid", 16'h0000, 1'b0, 1'b0, 1'b0); cyc();
    res = 1'b0;

    // Countdown to zero from 0003
    load = 1'b1; load_val = 16'h0003;
    expect_o("load0003", 16'h0003, 1'b0, 1'b0, 1'b0); cyc();
    load = 1'b0; start = 1'b1;
    expect_o("cz_start", 16'h0003, 1'b1, 1'b0, 1'b0); cyc();
    start = 1'b0;
    run_hold("cz_wait3", 16'h0003, 3);
    expect_o("cz_step2", 16'h0002, 1'b1, 1'b0, 1'b1); cyc();
    run_hold("cz_wait2", 16'h0002, 3);
    expect_o("cz_step1", 16'h0001, 1'b1, 1'b0, 1'b1); cyc();
    run_hold("cz_wait1", 16'h0001, 3);
    expect_o("cz_zero", 16'h0000, 1'b0, 1'b1, 1'b1); cyc();
    expect_o("cz_stb_once", 16'h0000, 1'b0, 1'b0, 1'b0); cyc();
    start = 1'b1;
    expect_o("done_start", 16'h0000, 1'b0, 1'b0, 1'b0); cyc();
    start = 1'b0;
    expect_o("done_hold", 16'h0000, 1'b0, 1'b0, 1'b0); cyc();

    // Pause and resume with partial tick retained
    load = 1'b1; load_val = 16'h0005;
    expect_o("load0005", 16'h0005, 1'b0, 1'b0, 1'b0); cyc();
    load = 1'b0; start = 1'b1;
    expect_o("pr_start", 16'h0005, 1'b1, 1'b0, 1'b0); cyc();
    start = 1'b0;
    run_hold("pr_wait", 16'h0005, 3);
    expect_o("pr_step4", 16'h0004, 1'b1, 1'b0, 1'b1); cyc();
    run_hold("pr_run", 16'h0004, 2);
    stop = 1'b1;
    expect_o("pr_stop", 16'h0004, 1'b0, 1'b0, 1'b0); cyc();
    for (int i = 0; i < 20; i++) begin
      stop = (i == 5);
      expect_o("pr_frozen", 16'h0004, 1'b0, 1'b0, 1'b0); cyc();
    end
    stop = 1'b0; start = 1'b1;
    expect_o("pr_resume", 16'h0004, 1'b1, 1'b0, 1'b0); cyc();
    start = 1'b0;
    expect_o("pr_resume1", 16'h0004, 1'b1, 1'b0, 1'b0); cyc();
    expect_o("pr_step3", 16'h0003, 1'b1, 1'b0, 1'b1); cyc();

    // Load on the terminal tick cycle wins
    load = 1'b1; load_val = 16'h0001;
    expect_o("load0001", 16'h0001, 1'b0, 1'b0, 1'b0); cyc();
    load = 1'b0; start = 1'b1;
    expect_o("lt_start", 16'h0001, 1'b1, 1'b0, 1'b0); cyc();
    start = 1'b0;
    run_hold("lt_wait", 16'h0001, 3);
    load = 1'b1; load_val = 16'h0001;
    expect_o("lt_override", 16'h0001, 1'b0, 1'b0, 1'b0); cyc();
    load = 1'b0;
    expect_o("lt_idle", 16'h0001, 1'b0, 1'b0, 1'b0); cyc();
    expect_o("lt_idle2", 16'h0001, 1'b0, 1'b0, 1'b0); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
